// File: rtl/bnn_infer_sequencer.sv
// ---------------------------------------------------------------------------
// bnn_infer_sequencer
//
// Runs one inference at a time through the BNN core. A frame is taken from
// the image buffer, latched and handed to the core. The core is started and
// the sequencer waits for its result. Results are queued in a 2-entry output
// FIFO with a valid/ready handshake. The FIFO applies backpressure: no new
// frame is accepted while it is full.
//
// Optional feature: define BNN_SEQ_TIMEOUT_EN to add a watchdog that aborts
// WAIT after TIMEOUT_CYCLES cycles. An aborted inference pushes an all-ones
// result tagged as a timeout and sets the sticky err_timeout flag. Without
// the macro, WAIT exits only on core_done, res_timeout and err_timeout stay
// 0, and err_clr is ignored.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   img_full     image buffer holds a complete frame
//   img_in       frame data, stable while img_full is high
//   img_consume  one-cycle pulse: frame taken, buffer may clear
//   core_img     registered frame driven to the BNN core
//   core_start   one-cycle start pulse to the core
//   core_done    core result valid (level or pulse)
//   core_result  core class index
//   res_valid    output FIFO non-empty
//   res_ready    consumer accepts the head entry
//   res_data     head-entry result
//   res_timeout  head entry was produced by a watchdog abort
//   busy         sequencer is not idle
//   infer_count  entries pushed since reset, wraps
//   err_timeout  sticky watchdog flag
//   err_clr      clears err_timeout
// ---------------------------------------------------------------------------
module bnn_infer_sequencer #(
   parameter int IMG_BITS       = 904,
   parameter int RESULT_W       = 4,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int CNT_W          = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                img_full,
   input  logic [IMG_BITS-1:0] img_in,
   output logic                img_consume,
   output logic [IMG_BITS-1:0] core_img,
   output logic                core_start,
   input  logic                core_done,
   input  logic [RESULT_W-1:0] core_result,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [RESULT_W-1:0] res_data,
   output logic                res_timeout,
   output logic                busy,
   output logic [CNT_W-1:0]    infer_count,
   output logic                err_timeout,
   input  logic                err_clr
);

   localparam int ENTRY_W = RESULT_W + 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT,
      PUSH
   } seqState_t;

   seqState_t            state;
   logic [RESULT_W-1:0]  capResult;
   logic                 capTag;
   logic                 wdogExpired;

   logic [ENTRY_W-1:0]   headEntry;
   logic [ENTRY_W-1:0]   tailEntry;
   logic                 headValid;
   logic                 tailValid;
   logic [ENTRY_W-1:0]   pushEntry;
   logic                 doPush;
   logic                 doPop;

   // The FIFO is pushed only from PUSH. The IDLE space check guarantees room,
   // because only pops can happen between IDLE and PUSH.
   assign doPush    = (state == PUSH);
   assign doPop     = headValid & res_ready;
   assign pushEntry = {capTag, capResult};

   // The FIFO head lives in dedicated registers, so the result outputs come
   // straight from flops.
   assign res_valid   = headValid;
   assign res_data    = headEntry[RESULT_W-1:0];
   assign res_timeout = headEntry[RESULT_W];

`ifdef BNN_SEQ_TIMEOUT_EN
   localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

   logic [WD_W-1:0] wdog;

   // The watchdog counts WAIT cycles. It is cleared in START, so it reads 0
   // in the first WAIT cycle. When it reaches TIMEOUT_CYCLES-1 it holds there,
   // and the FSM aborts on that same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdog <= '0;
      end else if (state == START) begin
         wdog <= '0;
      end else if (state == WAIT && !core_done && wdog != WD_MAX) begin
         wdog <= wdog + 1'b1;
      end
   end

   assign wdogExpired = (wdog == WD_MAX);

   // err_timeout is sticky. An abort that coincides with err_clr still sets
   // the flag, so the abort is never lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_timeout <= 1'b0;
      end else if (state == WAIT && !core_done && wdogExpired) begin
         err_timeout <= 1'b1;
      end else if (err_clr) begin
         err_timeout <= 1'b0;
      end
   end
`else
   logic unusedErrClr;

   assign wdogExpired  = 1'b0;
   assign err_timeout  = 1'b0;
   assign unusedErrClr = err_clr;
`endif

   // Main sequencer FSM. Every control output is a register and is updated
   // together with the state transition that it belongs to. img_consume and
   // core_start default to 0, so each stays high for exactly one cycle.
   // core_done has priority over a watchdog expiry on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         core_img    <= '0;
         img_consume <= 1'b0;
         core_start  <= 1'b0;
         busy        <= 1'b0;
         capResult   <= '0;
         capTag      <= 1'b0;
         infer_count <= '0;
      end else begin
         img_consume <= 1'b0;
         core_start  <= 1'b0;
         case (state)
            IDLE: begin
               if (img_full && !tailValid) begin
                  core_img    <= img_in;
                  img_consume <= 1'b1;
                  busy        <= 1'b1;
                  state       <= LOAD;
               end
            end
            LOAD: begin
               core_start <= 1'b1;
               state      <= START;
            end
            START: begin
               state <= WAIT;
            end
            WAIT: begin
               if (core_done) begin
                  capResult <= core_result;
                  capTag    <= 1'b0;
                  state     <= PUSH;
               end else if (wdogExpired) begin
                  capResult <= '1;
                  capTag    <= 1'b1;
                  state     <= PUSH;
               end
            end
            PUSH: begin
               infer_count <= infer_count + 1'b1;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // 2-entry output FIFO built from a head slot and a tail slot. A pop moves
   // the tail into the head. A push fills the first free slot after any pop
   // on the same edge, which keeps the entries in order. A simultaneous push
   // and pop therefore leaves the occupancy unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         headValid <= 1'b0;
         tailValid <= 1'b0;
         headEntry <= '0;
         tailEntry <= '0;
      end else begin
         case ({doPush, doPop})
            2'b01: begin
               if (tailValid) begin
                  headEntry <= tailEntry;
                  tailValid <= 1'b0;
               end else begin
                  headValid <= 1'b0;
               end
            end
            2'b10: begin
               if (!headValid) begin
                  headEntry <= pushEntry;
                  headValid <= 1'b1;
               end else begin
                  tailEntry <= pushEntry;
                  tailValid <= 1'b1;
               end
            end
            2'b11: begin
               if (tailValid) begin
                  headEntry <= tailEntry;
                  tailEntry <= pushEntry;
               end else begin
                  headEntry <= pushEntry;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bnn_infer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bnn_infer_sequencer
//
// Directed bench for bnn_infer_sequencer. The DUT uses a narrow frame,
// TIMEOUT_CYCLES=16 and CNT_W=2, so infer_count wraps inside a short run.
// The timeout scenario is exercised when BNN_SEQ_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bnn_infer_sequencer;

   localparam int IMG_BITS       = 32;
   localparam int RESULT_W       = 4;
   localparam int TIMEOUT_CYCLES = 16;
   localparam int CNT_W          = 2;

   logic                clk;
   logic                rst;
   logic                img_full;
   logic [IMG_BITS-1:0] img_in;
   logic                img_consume;
   logic [IMG_BITS-1:0] core_img;
   logic                core_start;
   logic                core_done;
   logic [RESULT_W-1:0] core_result;
   logic                res_valid;
   logic                res_ready;
   logic [RESULT_W-1:0] res_data;
   logic                res_timeout;
   logic                busy;
   logic [CNT_W-1:0]    infer_count;
   logic                err_timeout;
   logic                err_clr;

   int testCount = 0;
   int failCount = 0;

   bnn_infer_sequencer #(
      .IMG_BITS(IMG_BITS),
      .RESULT_W(RESULT_W),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .img_full(img_full),
      .img_in(img_in),
      .img_consume(img_consume),
      .core_img(core_img),
      .core_start(core_start),
      .core_done(core_done),
      .core_result(core_result),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .res_data(res_data),
      .res_timeout(res_timeout),
      .busy(busy),
      .infer_count(infer_count),
      .err_timeout(err_timeout),
      .err_clr(err_clr)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Absolute time bound, so a stuck run still ends.
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: observed still running expected finished");
      $fatal(1, "[TB] simulation time bound exceeded");
   end

   // Advance one rising edge, then settle 1 ns so that checks and input
   // changes both happen away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive every handshake and control input in one call.
   task automatic applyStimulus(input logic full, input logic done,
                                input logic [RESULT_W-1:0] result,
                                input logic ready, input logic clr);
      img_full    = full;
      core_done   = done;
      core_result = result;
      res_ready   = ready;
      err_clr     = clr;
   endtask

   // One comparison point: count it, and report it if it does not match.
   task automatic checkOutput(input string name, input logic [63:0] observed,
                              input logic [63:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
      end
   endtask

   // Compare every output against its reset value.
   task automatic checkResetState(input string prefix);
      checkOutput({prefix, "_core_img"},    64'(core_img),    64'h0);
      checkOutput({prefix, "_img_consume"}, 64'(img_consume), 64'h0);
      checkOutput({prefix, "_core_start"},  64'(core_start),  64'h0);
      checkOutput({prefix, "_res_valid"},   64'(res_valid),   64'h0);
      checkOutput({prefix, "_res_data"},    64'(res_data),    64'h0);
      checkOutput({prefix, "_res_timeout"}, 64'(res_timeout), 64'h0);
      checkOutput({prefix, "_busy"},        64'(busy),        64'h0);
      checkOutput({prefix, "_infer_count"}, 64'(infer_count), 64'h0);
      checkOutput({prefix, "_err_timeout"}, 64'(err_timeout), 64'h0);
   endtask

   // Start from the cycle after img_consume. Check the start pulse, return
   // core_done after waitCycles WAIT cycles, and step through PUSH.
   // popAtPush drives res_ready during the PUSH cycle.
   task automatic finishFrame(input logic [RESULT_W-1:0] result, input int waitCycles,
                              input logic popAtPush);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
      step();
      checkOutput("start_pulse",   64'(core_start),  64'h1);
      checkOutput("consume_clear", 64'(img_consume), 64'h0);
      step();
      checkOutput("start_clear",   64'(core_start),  64'h0);
      checkOutput("busy_wait",     64'(busy),        64'h1);
      repeat (waitCycles) step();
      applyStimulus(1'b0, 1'b1, result, 1'b0, 1'b0);
      step();
      checkOutput("busy_push",     64'(busy),        64'h1);
      applyStimulus(1'b0, 1'b0, '0, popAtPush, 1'b0);
      step();
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   // Present a frame, expect it to be taken on the next edge, then run it.
   task automatic runFrame(input logic [IMG_BITS-1:0] frame,
                           input logic [RESULT_W-1:0] result,
                           input int waitCycles, input logic popAtPush);
      img_in = frame;
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
      step();
      checkOutput("consume_pulse", 64'(img_consume), 64'h1);
      checkOutput("core_img",      64'(core_img),    64'(frame));
      finishFrame(result, waitCycles, popAtPush);
   endtask

   initial begin
      rst    = 1'b1;
      img_in = '0;
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
      repeat (2) step();
      checkResetState("reset");
      rst = 1'b0;
      step();

      // A core_done while idle must not start anything or push a result.
      applyStimulus(1'b0, 1'b1, 4'h3, 1'b0, 1'b0);
      repeat (2) step();
      checkOutput("idle_done_busy",  64'(busy),        64'h0);
      checkOutput("idle_done_valid", 64'(res_valid),   64'h0);
      checkOutput("idle_done_count", 64'(infer_count), 64'h0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);

      // Single frame with result 7.
      img_in = 32'hA5A5_1234;
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
      step();
      checkOutput("t1_consume", 64'(img_consume), 64'h1);
      checkOutput("t1_core_img", 64'(core_img),   64'hA5A5_1234);
      checkOutput("t1_busy",    64'(busy),        64'h1);
      checkOutput("t1_nostart", 64'(core_start),  64'h0);
      finishFrame(4'd7, 9, 1'b0);
      checkOutput("t1_valid",   64'(res_valid),   64'h1);
      checkOutput("t1_data",    64'(res_data),    64'h7);
      checkOutput("t1_tag",     64'(res_timeout), 64'h0);
      checkOutput("t1_count",   64'(infer_count), 64'h1);
      checkOutput("t1_idle",    64'(busy),        64'h0);
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
      step();
      checkOutput("t1_pop", 64'(res_valid), 64'h0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);

      // Backpressure: two queued results make the FIFO full, so frame 3 stalls.
      runFrame(32'h1, 4'd1, 2, 1'b0);
      checkOutput("bp_count1", 64'(infer_count), 64'h2);
      runFrame(32'h2, 4'd2, 0, 1'b0);
      checkOutput("bp_head1",  64'(res_data),    64'h1);
      checkOutput("bp_count2", 64'(infer_count), 64'h3);
      img_in = 32'h3;
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
      repeat (3) begin
         step();
         checkOutput("bp_stall_consume", 64'(img_consume), 64'h0);
         checkOutput("bp_stall_busy",    64'(busy),        64'h0);
      end
      applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0);
      step();
      checkOutput("bp_head2",     64'(res_data),    64'h2);
      checkOutput("bp_valid2",    64'(res_valid),   64'h1);
      checkOutput("bp_no_load",   64'(img_consume), 64'h0);
      step();
      checkOutput("bp_drained",   64'(res_valid),   64'h0);
      checkOutput("bp_f3_loaded", 64'(img_consume), 64'h1);
      finishFrame(4'd3, 1, 1'b0);
      checkOutput("bp_head3", 64'(res_data),    64'h3);
      checkOutput("bp_wrap0", 64'(infer_count), 64'h0);
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
      step();
      checkOutput("bp_pop3", 64'(res_valid), 64'h0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);

      // Same-cycle push and pop while the FIFO holds one entry.
      runFrame(32'h5, 4'd5, 0, 1'b0);
      checkOutput("pp_head5",  64'(res_data),    64'h5);
      checkOutput("pp_count1", 64'(infer_count), 64'h1);
      runFrame(32'h6, 4'd6, 0, 1'b1);
      checkOutput("pp_valid",  64'(res_valid),   64'h1);
      checkOutput("pp_head6",  64'(res_data),    64'h6);
      checkOutput("pp_count2", 64'(infer_count), 64'h2);
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
      step();
      checkOutput("pp_single", 64'(res_valid), 64'h0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);

`ifdef BNN_SEQ_TIMEOUT_EN
      // Watchdog abort: core_done is never asserted.
      img_in = 32'hDEAD_BEEF;
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
      step();
      checkOutput("to_consume", 64'(img_consume), 64'h1);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
      step();
      step();
      repeat (TIMEOUT_CYCLES - 1) begin
         step();
         checkOutput("to_err_early", 64'(err_timeout), 64'h0);
         checkOutput("to_busy",      64'(busy),        64'h1);
      end
      step();
      checkOutput("to_err_set",   64'(err_timeout), 64'h1);
      checkOutput("to_not_yet",   64'(res_valid),   64'h0);
      step();
      checkOutput("to_valid",     64'(res_valid),   64'h1);
      checkOutput("to_data",      64'(res_data),    64'hF);
      checkOutput("to_tag",       64'(res_timeout), 64'h1);
      checkOutput("to_count",     64'(infer_count), 64'h3);
      checkOutput("to_idle",      64'(busy),        64'h0);
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
      step();
      checkOutput("to_err_clr",   64'(err_timeout), 64'h0);
      checkOutput("to_pop",       64'(res_valid),   64'h0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
`else
      // Without the watchdog, err_clr has no effect and the flags stay low.
      runFrame(32'hC, 4'hC, 20, 1'b0);
      checkOutput("nt_data",  64'(res_data),    64'hC);
      checkOutput("nt_tag",   64'(res_timeout), 64'h0);
      checkOutput("nt_count", 64'(infer_count), 64'h3);
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
      step();
      checkOutput("nt_err",   64'(err_timeout), 64'h0);
      checkOutput("nt_pop",   64'(res_valid),   64'h0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
`endif

      // Reset during WAIT with one result still queued.
      runFrame(32'h8, 4'd8, 0, 1'b0);
      checkOutput("rw_count", 64'(infer_count), 64'h0);
      img_in = 32'h9;
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
      step();
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
      repeat (3) step();
      checkOutput("rw_in_wait", 64'(busy), 64'h1);
      rst = 1'b1;
      step();
      checkResetState("rw");
      rst = 1'b0;
      applyStimulus(1'b0, 1'b1, 4'h9, 1'b0, 1'b0);
      repeat (3) begin
         step();
         checkOutput("rw_stray_start", 64'(core_start), 64'h0);
      end
      checkOutput("rw_stray_busy",  64'(busy),        64'h0);
      checkOutput("rw_stray_valid", 64'(res_valid),   64'h0);
      checkOutput("rw_stray_count", 64'(infer_count), 64'h0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
